// File: rtl/perceptron_trainer.sv
// Serial perceptron trainer: one MAC per cycle, sign-mismatch weight/bias
// update, repeated epochs until an error-free epoch or the epoch limit.
// Ports: clk, rst (async, active-low), start, n_samples, max_epochs,
//   s_valid/s_ready/s_x/s_t sample stream, epoch_req, busy, done,
//   converged, epoch_cnt, err_cnt, w (packed weights), b (bias).
module perceptron_trainer #(
  parameter int NUM_IN = 2,
  parameter int X_W    = 7,
  parameter int W_W    = 14,
  parameter int FRAC   = 4,
  parameter int LR     = 12,
  parameter int B_LR   = 192,
  parameter int CNT_W  = 32,
  parameter int EP_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        n_samples,
  input  logic [EP_W-1:0]         max_epochs,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [NUM_IN*X_W-1:0]   s_x,
  input  logic                    s_t,
  output logic                    epoch_req,
  output logic                    busy,
  output logic                    done,
  output logic                    converged,
  output logic [EP_W-1:0]         epoch_cnt,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [NUM_IN*W_W-1:0]   w,
  output logic [W_W-1:0]          b
);

  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int AW = X_W + W_W + $clog2(NUM_IN) + 1;
  localparam int YW = AW + 1;
  localparam int UW = W_W + X_W + 18;

  localparam logic signed [UW-1:0] WMAX =
    {{(UW-W_W+1){1'b0}}, {(W_W-1){1'b1}}};
  localparam logic signed [UW-1:0] WMIN =
    {{(UW-W_W+1){1'b1}}, {(W_W-1){1'b0}}};
  localparam logic signed [UW-1:0] LR_S  = UW'(LR);
  localparam logic signed [UW-1:0] BLR_S = UW'(B_LR);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] MAC    = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] UPDATE = 3'd4;
  localparam logic [2:0] EP_END = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  logic [2:0]              st;
  logic signed [W_W-1:0]   wr [NUM_IN];
  logic signed [W_W-1:0]   wn [NUM_IN];
  logic signed [X_W-1:0]   xr [NUM_IN];
  logic signed [W_W-1:0]   br;
  logic signed [W_W-1:0]   bn;
  logic                    tr;
  logic signed [AW-1:0]    acc;
  logic [IW-1:0]           idx;
  logic [CNT_W-1:0]        n_lat;
  logic [CNT_W-1:0]        smp;
  logic [EP_W-1:0]         m_lat;
  logic [EP_W-1:0]         ep_n;
  logic signed [W_W+X_W-1:0] prod;
  logic signed [YW-1:0]    acc_x;
  logic signed [YW-1:0]    y;
  logic                    wrong;

  function automatic logic signed [W_W-1:0] sat(
    input logic signed [UW-1:0] v
  );
    if (v > WMAX)      return WMAX[W_W-1:0];
    else if (v < WMIN) return WMIN[W_W-1:0];
    else               return v[W_W-1:0];
  endfunction

  assign prod  = wr[idx] * xr[idx];
  assign acc_x = acc;
  // Floor shift at full width, then bias; sign bit gives the prediction.
  assign y     = (acc_x >>> FRAC) + br;
  assign wrong = (~y[YW-1]) != tr;
  assign ep_n  = (&epoch_cnt) ? epoch_cnt : epoch_cnt + EP_W'(1);

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      wn[i] = sat(UW'(wr[i]) + (tr ? LR_S * UW'(xr[i])
                                   : -(LR_S * UW'(xr[i]))));
    end
    bn = sat(UW'(br) + (tr ? BLR_S : -BLR_S));
  end

  assign s_ready = (st == LOAD);
  assign busy    = (st != IDLE) && (st != DONE);
  assign b       = br;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_w
    assign w[g*W_W +: W_W] = wr[g];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      br        <= '0;
      tr        <= 1'b0;
      acc       <= '0;
      idx       <= '0;
      n_lat     <= '0;
      m_lat     <= '0;
      smp       <= '0;
      epoch_req <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
      epoch_cnt <= '0;
      err_cnt   <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        wr[i] <= '0;
        xr[i] <= '0;
      end
    end else begin
      epoch_req <= 1'b0;
      case (st)
        IDLE, DONE: begin
          if (start) begin
            n_lat     <= n_samples;
            m_lat     <= max_epochs;
            br        <= '0;
            epoch_cnt <= '0;
            err_cnt   <= '0;
            smp       <= '0;
            for (int i = 0; i < NUM_IN; i++) wr[i] <= '0;
            if (n_samples == '0) begin
              st        <= DONE;
              done      <= 1'b1;
              converged <= 1'b1;
            end else begin
              st        <= LOAD;
              done      <= 1'b0;
              converged <= 1'b0;
              epoch_req <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (s_valid) begin
            for (int i = 0; i < NUM_IN; i++)
              xr[i] <= s_x[i*X_W +: X_W];
            tr  <= s_t;
            acc <= '0;
            idx <= '0;
            st  <= MAC;
          end
        end
        MAC: begin
          acc <= acc + AW'(prod);
          idx <= idx + IW'(1);
          if (idx == IW'(NUM_IN - 1)) st <= CHECK;
        end
        CHECK: begin
          smp <= smp + CNT_W'(1);
          if (wrong) begin
            err_cnt <= err_cnt + CNT_W'(1);
            st      <= UPDATE;
          end else if (smp + CNT_W'(1) == n_lat) begin
            st <= EP_END;
          end else begin
            st <= LOAD;
          end
        end
        UPDATE: begin
          br <= bn;
          for (int i = 0; i < NUM_IN; i++) wr[i] <= wn[i];
          st <= (smp == n_lat) ? EP_END : LOAD;
        end
        EP_END: begin
          epoch_cnt <= ep_n;
          if (err_cnt == '0) begin
            st        <= DONE;
            done      <= 1'b1;
            converged <= 1'b1;
          end else if (m_lat != '0 && ep_n == m_lat) begin
            st        <= DONE;
            done      <= 1'b1;
            converged <= 1'b0;
          end else begin
            err_cnt   <= '0;
            smp       <= '0;
            epoch_req <= 1'b1;
            st        <= LOAD;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
